// File: rtl/medi_pkg.sv
// ---------------------------------------------------------------------------
// medi_pkg
// Shared definitions for the pill-box reminder controller.
//   state_t        : FSM state encoding, also driven out on state_out
//   disabled_code  : all-ones time code that marks a slot as unused
//   slot_index     : flat slot number of box b, slot s
// ---------------------------------------------------------------------------
package medi_pkg;

    // Encoding is visible on state_out, so the codes are fixed explicitly.
    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SET   = 3'd2,
        ST_READY = 3'd3,
        ST_ARMED = 3'd4,
        ST_ALERT = 3'd5
    } state_t;

    // All-ones code of the given width; callers truncate to their time width.
    function automatic logic [31:0] disabled_code(input int tw);
        return (32'd1 << tw) - 32'd1;
    endfunction

    // Slots are stored box-major: all slots of box 0 first, then box 1, ...
    function automatic int slot_index(input int b, input int s, input int n_slot);
        return b * n_slot + s;
    endfunction

endpackage

// File: rtl/medi_slot_match.sv
// ---------------------------------------------------------------------------
// medi_slot_match
// Combinational compare of the current time code against every stored slot.
//   cfg_time  in   N_BOX*N_SLOT*TW  stored slots, box-major
//   time_in   in   TW               current time code
//   hit       out  N_BOX            box b has at least one enabled slot equal
//                                   to time_in
// ---------------------------------------------------------------------------
module medi_slot_match
    import medi_pkg::*;
#(
    parameter int N_BOX  = 3,
    parameter int N_SLOT = 2,
    parameter int TW     = 7
) (
    input  logic [N_BOX*N_SLOT*TW-1:0] cfg_time,
    input  logic [TW-1:0]              time_in,
    output logic [N_BOX-1:0]           hit
);

    localparam logic [TW-1:0] DISABLED = TW'(disabled_code(TW));

    // A disabled slot never matches, even when time_in carries the same
    // all-ones code, so an unused slot can never raise an alert.
    always_comb begin
        hit = '0;
        for (int b = 0; b < N_BOX; b++) begin
            for (int s = 0; s < N_SLOT; s++) begin
                if ((cfg_time[slot_index(b, s, N_SLOT)*TW +: TW] != DISABLED) &&
                    (cfg_time[slot_index(b, s, N_SLOT)*TW +: TW] == time_in)) begin
                    hit[b] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/medi_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// medi_alarm_ctrl
// Pill-box reminder controller: N_BOX boxes with N_SLOT dose times each.
//   clkin      in   1        system clock
//   rst_n      in   1        asynchronous reset, active-low
//   btn_pwr    in   1        power toggle OFF<->IDLE, clears everything
//   btn_set    in   1        enter SET / store time_in into current slot
//   btn_start  in   1        READY -> ARMED
//   btn_ack    in   1        dose taken, clears the active alert
//   btn_skip   in   1        in SET: store DISABLED into current slot
//   tick       in   1        one pulse per second, time_in valid on it
//   time_in    in   TW       current time code
//   cfg_time   out  slots    stored slot codes, box b slot s at (b*N_SLOT+s)*TW
//   miss_cnt   out  N_BOX*CNT_W  saturating missed-dose counters
//   alert_box  out  N_BOX    one-hot box being alerted, 0 when none
//   pend       out  N_BOX    boxes waiting behind the active alert
//   set_idx    out  IDX_W    slot index being programmed
//   state_out  out  3        current FSM state code
// ---------------------------------------------------------------------------
module medi_alarm_ctrl
    import medi_pkg::*;
#(
    parameter int N_BOX    = 3,
    parameter int N_SLOT   = 2,
    parameter int TW       = 7,
    parameter int CNT_W    = 5,
    parameter int ALERT_TO = 60,
    // A single-slot configuration still gets a 1-bit index port.
    localparam int IDX_W   = (N_BOX * N_SLOT > 1) ? $clog2(N_BOX * N_SLOT) : 1
) (
    input  logic                      clkin,
    input  logic                      rst_n,
    input  logic                      btn_pwr,
    input  logic                      btn_set,
    input  logic                      btn_start,
    input  logic                      btn_ack,
    input  logic                      btn_skip,
    input  logic                      tick,
    input  logic [TW-1:0]             time_in,
    output logic [N_BOX*N_SLOT*TW-1:0] cfg_time,
    output logic [N_BOX*CNT_W-1:0]    miss_cnt,
    output logic [N_BOX-1:0]          alert_box,
    output logic [N_BOX-1:0]          pend,
    output logic [IDX_W-1:0]          set_idx,
    output logic [2:0]                state_out
);

    localparam int              N_SLOTS  = N_BOX * N_SLOT;
    localparam int              LAST     = N_SLOTS - 1;
    localparam int              TMR_W    = $clog2(ALERT_TO + 1);
    localparam logic [TW-1:0]   DISABLED = TW'(disabled_code(TW));

    state_t                      state;
    state_t                      state_nxt;
    logic [TMR_W-1:0]            timer;
    logic [TMR_W-1:0]            timer_nxt;
    logic [N_SLOTS*TW-1:0]       cfg_nxt;
    logic [N_BOX*CNT_W-1:0]      miss_nxt;
    logic [N_BOX-1:0]            alert_nxt;
    logic [N_BOX-1:0]            pend_nxt;
    logic [IDX_W-1:0]            idx_nxt;

    logic [N_BOX-1:0]            hit;
    logic [N_BOX-1:0]            hit_t;
    logic [N_BOX-1:0]            pend_merged;
    logic [N_BOX-1:0]            inc_vec;
    logic                        active_hit;
    logic                        timeout;
    logic                        release_alert;

    // Isolates the lowest set bit, which gives lowest-index-first priority.
    function automatic logic [N_BOX-1:0] lowest_one(input logic [N_BOX-1:0] v);
        return v & (~v + N_BOX'(1));
    endfunction

    medi_slot_match #(
        .N_BOX  (N_BOX),
        .N_SLOT (N_SLOT),
        .TW     (TW)
    ) u_match (
        .cfg_time (cfg_time),
        .time_in  (time_in),
        .hit      (hit)
    );

    assign state_out = state;

    // Alert bookkeeping for the current cycle. Hits only count on a tick.
    // The active box is charged a miss on a re-hit or a timeout unless the
    // ack arrives in the same cycle; an already-pending box that hits again
    // is charged a miss as well.
    always_comb begin
        hit_t         = tick ? hit : '0;
        active_hit    = |(hit_t & alert_box);
        timeout       = tick && (timer == TMR_W'(ALERT_TO - 1));
        release_alert = btn_ack || (timeout && !active_hit);
        pend_merged   = pend | (hit_t & ~alert_box);
        inc_vec       = hit_t & pend & ~alert_box;
        if (!btn_ack && (active_hit || timeout)) begin
            inc_vec = inc_vec | alert_box;
        end
    end

    // State register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Power toggling overrides every other input.
    always_comb begin
        state_nxt = state;
        if (btn_pwr) begin
            state_nxt = (state == ST_OFF) ? ST_IDLE : ST_OFF;
        end else begin
            case (state)
                ST_OFF:   state_nxt = ST_OFF;
                ST_IDLE:  if (btn_set) state_nxt = ST_SET;
                ST_SET: begin
                    if ((btn_set || btn_skip) && (set_idx == IDX_W'(LAST))) begin
                        state_nxt = ST_READY;
                    end
                end
                ST_READY: begin
                    if (btn_start) begin
                        state_nxt = ST_ARMED;
                    end else if (btn_set) begin
                        state_nxt = ST_SET;
                    end
                end
                ST_ARMED: if (|hit_t) state_nxt = ST_ALERT;
                ST_ALERT: begin
                    if (release_alert && (pend_merged == '0)) begin
                        state_nxt = ST_ARMED;
                    end
                end
                default:  state_nxt = ST_OFF;
            endcase
        end
    end

    // Next values of the registered outputs and the alert timer.
    // Powering down from any live state restores the reset contents.
    always_comb begin
        cfg_nxt   = cfg_time;
        miss_nxt  = miss_cnt;
        alert_nxt = alert_box;
        pend_nxt  = pend;
        idx_nxt   = set_idx;
        timer_nxt = timer;
        if (btn_pwr) begin
            if (state != ST_OFF) begin
                cfg_nxt   = {N_SLOTS{DISABLED}};
                miss_nxt  = '0;
                alert_nxt = '0;
                pend_nxt  = '0;
                idx_nxt   = '0;
                timer_nxt = '0;
            end
        end else begin
            case (state)
                ST_IDLE: if (btn_set) idx_nxt = '0;
                ST_SET: begin
                    if (btn_set || btn_skip) begin
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (i == int'(set_idx)) begin
                                cfg_nxt[i*TW +: TW] = btn_skip ? DISABLED : time_in;
                            end
                        end
                        idx_nxt = (set_idx == IDX_W'(LAST)) ? '0 : set_idx + IDX_W'(1);
                    end
                end
                ST_READY: if (!btn_start && btn_set) idx_nxt = '0;
                ST_ARMED: begin
                    if (|hit_t) begin
                        alert_nxt = lowest_one(hit_t);
                        pend_nxt  = pend | (hit_t & ~lowest_one(hit_t));
                        timer_nxt = '0;
                    end
                end
                ST_ALERT: begin
                    pend_nxt = pend_merged;
                    for (int b = 0; b < N_BOX; b++) begin
                        if (inc_vec[b] && (miss_cnt[b*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                            miss_nxt[b*CNT_W +: CNT_W] = miss_cnt[b*CNT_W +: CNT_W] + CNT_W'(1);
                        end
                    end
                    // On release the lowest waiting box takes over; with
                    // nothing waiting this yields zero and the FSM re-arms.
                    if (release_alert) begin
                        alert_nxt = lowest_one(pend_merged);
                        pend_nxt  = pend_merged & ~lowest_one(pend_merged);
                        timer_nxt = '0;
                    end else if (active_hit) begin
                        timer_nxt = '0;
                    end else if (tick) begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cfg_time  <= {N_SLOTS{DISABLED}};
            miss_cnt  <= '0;
            alert_box <= '0;
            pend      <= '0;
            set_idx   <= '0;
            timer     <= '0;
        end else begin
            cfg_time  <= cfg_nxt;
            miss_cnt  <= miss_nxt;
            alert_box <= alert_nxt;
            pend      <= pend_nxt;
            set_idx   <= idx_nxt;
            timer     <= timer_nxt;
        end
    end

endmodule

// File: tb/tb_medi_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_medi_alarm_ctrl
// Scoreboard bench for medi_alarm_ctrl. A main instance (3 boxes x 2 slots,
// 2-bit counters, 4-tick timeout) runs the alert scenarios; two more
// instances (1x1 and 4x4) check the programming sequence length.
// ---------------------------------------------------------------------------
module tb_medi_alarm_ctrl;

    localparam int K_STATE = 0;
    localparam int K_ALERT = 1;
    localparam int K_PEND  = 2;
    localparam int K_MISS  = 3;
    localparam int K_CFG   = 4;
    localparam int K_IDX   = 5;

    // Button vector bits: {tick, skip, ack, start, set, pwr}
    localparam logic [5:0] B_PWR   = 6'b000001;
    localparam logic [5:0] B_SET   = 6'b000010;
    localparam logic [5:0] B_START = 6'b000100;
    localparam logic [5:0] B_ACK   = 6'b001000;
    localparam logic [5:0] B_SKIP  = 6'b010000;
    localparam logic [5:0] B_TICK  = 6'b100000;

    localparam logic [41:0] CFG_ONES = {42{1'b1}};
    localparam logic [41:0] CFG1 = {7'd50, 7'd40, 7'd30, 7'd127, 7'd20, 7'd10};
    localparam logic [41:0] CFG2 = {7'd50, 7'd40, 7'd30, 7'd127, 7'd40, 7'd10};

    typedef struct packed {
        logic [1:0]   dut;
        logic [2:0]   kind;
        logic [127:0] expv;
    } chk_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  btn_m;
    logic [5:0]  btn_a;
    logic [5:0]  btn_b;
    logic [6:0]  time_in;

    logic [41:0] m_cfg;
    logic [5:0]  m_miss;
    logic [2:0]  m_alert;
    logic [2:0]  m_pend;
    logic [2:0]  m_idx;
    logic [2:0]  m_state;

    logic [6:0]  a_cfg;
    logic [4:0]  a_miss;
    logic [0:0]  a_alert;
    logic [0:0]  a_pend;
    logic [0:0]  a_idx;
    logic [2:0]  a_state;

    logic [111:0] b_cfg;
    logic [19:0]  b_miss;
    logic [3:0]   b_alert;
    logic [3:0]   b_pend;
    logic [3:0]   b_idx;
    logic [2:0]   b_state;

    chk_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    medi_alarm_ctrl #(.N_BOX(3), .N_SLOT(2), .TW(7), .CNT_W(2), .ALERT_TO(4)) dut (
        .clkin(clk), .rst_n(rst_n),
        .btn_pwr(btn_m[0]), .btn_set(btn_m[1]), .btn_start(btn_m[2]),
        .btn_ack(btn_m[3]), .btn_skip(btn_m[4]), .tick(btn_m[5]),
        .time_in(time_in),
        .cfg_time(m_cfg), .miss_cnt(m_miss), .alert_box(m_alert),
        .pend(m_pend), .set_idx(m_idx), .state_out(m_state)
    );

    medi_alarm_ctrl #(.N_BOX(1), .N_SLOT(1), .TW(7), .CNT_W(5), .ALERT_TO(60)) dut_a (
        .clkin(clk), .rst_n(rst_n),
        .btn_pwr(btn_a[0]), .btn_set(btn_a[1]), .btn_start(btn_a[2]),
        .btn_ack(btn_a[3]), .btn_skip(btn_a[4]), .tick(btn_a[5]),
        .time_in(time_in),
        .cfg_time(a_cfg), .miss_cnt(a_miss), .alert_box(a_alert),
        .pend(a_pend), .set_idx(a_idx), .state_out(a_state)
    );

    medi_alarm_ctrl #(.N_BOX(4), .N_SLOT(4), .TW(7), .CNT_W(5), .ALERT_TO(60)) dut_b (
        .clkin(clk), .rst_n(rst_n),
        .btn_pwr(btn_b[0]), .btn_set(btn_b[1]), .btn_start(btn_b[2]),
        .btn_ack(btn_b[3]), .btn_skip(btn_b[4]), .tick(btn_b[5]),
        .time_in(time_in),
        .cfg_time(b_cfg), .miss_cnt(b_miss), .alert_box(b_alert),
        .pend(b_pend), .set_idx(b_idx), .state_out(b_state)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Picks the observed output for one scoreboard entry.
    function automatic logic [127:0] actual(input logic [1:0] d, input logic [2:0] k);
        logic [127:0] r;
        r = '0;
        case (d)
            2'd0: case (k)
                3'(K_STATE): r = 128'(m_state);
                3'(K_ALERT): r = 128'(m_alert);
                3'(K_PEND):  r = 128'(m_pend);
                3'(K_MISS):  r = 128'(m_miss);
                3'(K_CFG):   r = 128'(m_cfg);
                default:     r = 128'(m_idx);
            endcase
            2'd1: case (k)
                3'(K_STATE): r = 128'(a_state);
                3'(K_CFG):   r = 128'(a_cfg);
                default:     r = 128'(a_idx);
            endcase
            default: case (k)
                3'(K_STATE): r = 128'(b_state);
                3'(K_CFG):   r = 128'(b_cfg);
                default:     r = 128'(b_idx);
            endcase
        endcase
        return r;
    endfunction

    // Monitor: just after every falling edge, drain whatever the stimulus
    // queued since the last rising edge and compare against the outputs.
    initial begin
        chk_t         c;
        string        nm;
        logic [127:0] got;
        forever begin
            @(negedge clk);
            #1;
            while (exp_q.size() > 0) begin
                c   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = actual(c.dut, c.kind);
                checks++;
                if (got !== c.expv) begin
                    errors++;
                    $display("[TB] FAIL %s got=%0h expected=%0h", nm, got, c.expv);
                end
            end
        end
    end

    // Drives one cycle's worth of buttons on the selected instance.
    task automatic applyStimulus(input int d, input logic [5:0] btn, input logic [6:0] t);
        @(negedge clk);
        time_in = t;
        case (d)
            0:       btn_m = btn;
            1:       btn_a = btn;
            default: btn_b = btn;
        endcase
        @(posedge clk);
        #1;
        btn_m = '0;
        btn_a = '0;
        btn_b = '0;
    endtask

    // Queues one expected value for the monitor.
    task automatic checkOutput(input int d, input int k, input logic [127:0] e, input string nm);
        chk_t c;
        c.dut  = 2'(d);
        c.kind = 3'(k);
        c.expv = e;
        exp_q.push_back(c);
        name_q.push_back(nm);
    endtask

    // Programs all six main-instance slots; slot skip_idx is skipped with
    // set and skip pressed together.
    task automatic programAll(input logic [41:0] vals, input int skip_idx);
        for (int i = 0; i < 6; i++) begin
            if (i == skip_idx) applyStimulus(0, B_SET | B_SKIP, 7'd99);
            else               applyStimulus(0, B_SET, vals[i*7 +: 7]);
            if (i == 4) begin
                checkOutput(0, K_STATE, 128'(3'd2), "set_before_last");
                checkOutput(0, K_IDX, 128'(3'd5), "idx_before_last");
            end
        end
    endtask

    task automatic ticks(input int n, input logic [6:0] t);
        for (int i = 0; i < n; i++) applyStimulus(0, B_TICK, t);
    endtask

    // Main scenario sequence.
    initial begin
        rst_n   = 1'b0;
        btn_m   = '0;
        btn_a   = '0;
        btn_b   = '0;
        time_in = '0;

        checkOutput(0, K_STATE, 128'(3'd0), "reset_state");
        checkOutput(0, K_CFG, 128'(CFG_ONES), "reset_cfg");
        checkOutput(0, K_MISS, 128'(6'd0), "reset_miss");
        checkOutput(0, K_ALERT, 128'(3'd0), "reset_alert");
        checkOutput(0, K_PEND, 128'(3'd0), "reset_pend");
        checkOutput(0, K_IDX, 128'(3'd0), "reset_idx");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Program 10,20,skip,30,40,50 and arm.
        applyStimulus(0, B_PWR, 7'd0);
        checkOutput(0, K_STATE, 128'(3'd1), "pwr_idle");
        applyStimulus(0, B_SET, 7'd0);
        checkOutput(0, K_STATE, 128'(3'd2), "enter_set");
        programAll(CFG1, 2);
        checkOutput(0, K_STATE, 128'(3'd3), "ready");
        checkOutput(0, K_IDX, 128'(3'd0), "ready_idx");
        checkOutput(0, K_CFG, 128'(CFG1), "cfg1");
        applyStimulus(0, B_START, 7'd0);
        checkOutput(0, K_STATE, 128'(3'd4), "armed");
        checkOutput(0, K_MISS, 128'(6'd0), "armed_miss");
        applyStimulus(0, B_TICK, 7'd127);
        checkOutput(0, K_STATE, 128'(3'd4), "disabled_no_match");

        // Single alert acknowledged before timeout.
        applyStimulus(0, B_TICK, 7'd10);
        checkOutput(0, K_STATE, 128'(3'd5), "alert_state");
        checkOutput(0, K_ALERT, 128'(3'b001), "alert_box0");
        ticks(3, 7'd0);
        checkOutput(0, K_ALERT, 128'(3'b001), "alert_held");
        applyStimulus(0, B_ACK, 7'd0);
        checkOutput(0, K_ALERT, 128'(3'b000), "ack_clear");
        checkOutput(0, K_STATE, 128'(3'd4), "ack_armed");
        checkOutput(0, K_MISS, 128'(6'd0), "ack_no_miss");

        // Reprogram with boxes 0 and 2 sharing time 40.
        applyStimulus(0, B_PWR, 7'd0);
        checkOutput(0, K_STATE, 128'(3'd0), "pwr_off");
        applyStimulus(0, B_PWR, 7'd0);
        applyStimulus(0, B_SET, 7'd0);
        programAll(CFG2, 2);
        checkOutput(0, K_CFG, 128'(CFG2), "cfg2");
        applyStimulus(0, B_START, 7'd0);

        // Shared time: box0 active, box2 pending; timeout hands over.
        applyStimulus(0, B_TICK, 7'd40);
        checkOutput(0, K_ALERT, 128'(3'b001), "shared_alert");
        checkOutput(0, K_PEND, 128'(3'b100), "shared_pend");
        ticks(3, 7'd0);
        checkOutput(0, K_MISS, 128'(6'd0), "before_timeout");
        ticks(1, 7'd0);
        checkOutput(0, K_MISS, 128'(6'b000001), "timeout_miss");
        checkOutput(0, K_ALERT, 128'(3'b100), "handover_alert");
        checkOutput(0, K_PEND, 128'(3'b000), "handover_pend");
        checkOutput(0, K_STATE, 128'(3'd5), "handover_state");
        applyStimulus(0, B_ACK, 7'd0);
        checkOutput(0, K_STATE, 128'(3'd4), "handover_ack");

        // Ack arriving together with the timeout tick wins.
        applyStimulus(0, B_TICK, 7'd30);
        checkOutput(0, K_ALERT, 128'(3'b010), "box1_alert");
        ticks(3, 7'd0);
        applyStimulus(0, B_TICK | B_ACK, 7'd0);
        checkOutput(0, K_ALERT, 128'(3'b000), "ack_timeout_alert");
        checkOutput(0, K_STATE, 128'(3'd4), "ack_timeout_state");
        checkOutput(0, K_MISS, 128'(6'b000001), "ack_timeout_miss");

        // Five timeouts on box 1 saturate its 2-bit counter at 3.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, B_TICK, 7'd30);
            ticks(4, 7'd0);
            checkOutput(0, K_MISS, 128'({2'b00, 2'((k > 3) ? 3 : k), 2'b01}), "sat_miss");
            checkOutput(0, K_STATE, 128'(3'd4), "sat_state");
        end

        // Re-hit of active box and of a pending box both count.
        applyStimulus(0, B_TICK, 7'd40);
        applyStimulus(0, B_TICK, 7'd40);
        checkOutput(0, K_ALERT, 128'(3'b001), "rehit_alert");
        checkOutput(0, K_PEND, 128'(3'b100), "rehit_pend");
        checkOutput(0, K_MISS, 128'(6'b011110), "rehit_miss");
        applyStimulus(0, B_ACK, 7'd0);
        checkOutput(0, K_ALERT, 128'(3'b100), "rehit_handover");
        checkOutput(0, K_STATE, 128'(3'd5), "rehit_still_alert");

        // Power-off during ALERT restores reset contents.
        applyStimulus(0, B_PWR, 7'd0);
        checkOutput(0, K_STATE, 128'(3'd0), "pwroff_state");
        checkOutput(0, K_CFG, 128'(CFG_ONES), "pwroff_cfg");
        checkOutput(0, K_MISS, 128'(6'd0), "pwroff_miss");
        checkOutput(0, K_ALERT, 128'(3'd0), "pwroff_alert");
        checkOutput(0, K_PEND, 128'(3'd0), "pwroff_pend");

        // Asynchronous reset in the middle of SET.
        applyStimulus(0, B_PWR, 7'd0);
        applyStimulus(0, B_SET, 7'd0);
        applyStimulus(0, B_SET, 7'd10);
        applyStimulus(0, B_SET, 7'd20);
        checkOutput(0, K_IDX, 128'(3'd2), "midset_idx");
        checkOutput(0, K_CFG, 128'({28'hFFFFFFF, 7'd20, 7'd10}), "midset_cfg");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        checkOutput(0, K_STATE, 128'(3'd0), "rst_state");
        checkOutput(0, K_CFG, 128'(CFG_ONES), "rst_cfg");
        checkOutput(0, K_IDX, 128'(3'd0), "rst_idx");
        checkOutput(0, K_MISS, 128'(6'd0), "rst_miss");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1x1: a single store reaches READY.
        applyStimulus(1, B_PWR, 7'd0);
        applyStimulus(1, B_SET, 7'd0);
        checkOutput(1, K_STATE, 128'(3'd2), "a_set");
        applyStimulus(1, B_SET, 7'd5);
        checkOutput(1, K_STATE, 128'(3'd3), "a_ready");
        checkOutput(1, K_IDX, 128'(1'b0), "a_idx");
        checkOutput(1, K_CFG, 128'(7'd5), "a_cfg");

        // 4x4: still in SET after 15 stores, READY after 16.
        applyStimulus(2, B_PWR, 7'd0);
        applyStimulus(2, B_SET, 7'd0);
        for (int i = 0; i < 15; i++) applyStimulus(2, B_SET, 7'(i));
        checkOutput(2, K_STATE, 128'(3'd2), "b_set_15");
        checkOutput(2, K_IDX, 128'(4'd15), "b_idx_15");
        applyStimulus(2, B_SET, 7'd15);
        checkOutput(2, K_STATE, 128'(3'd3), "b_ready");
        checkOutput(2, K_IDX, 128'(4'd0), "b_idx_0");

        // Let the monitor drain; leftovers are reported as failures.
        repeat (3) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            errors += exp_q.size();
            $display("[TB] FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
